// File: rtl/npc_axi_pkg.sv
// Shared AXI4-Lite definitions for the NPC memory path: response codes and the
// SRAM responder state encoding, reused by the IFU-side master and the arbiter.
package npc_axi_pkg;

  localparam int unsigned RESP_W = 2;

  localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    W_COLLECT,
    R_DELAY,
    R_RESP,
    W_DELAY,
    W_RESP
  } axil_sram_state_t;

endpackage

// File: rtl/sram_word_array.sv
// Word-organised storage: one synchronous read port, one byte-strobed write port.
// No reset so it maps onto a memory macro or a DPI-backed model.
module sram_word_array #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IDX_W  = $clog2(DEPTH),
  parameter int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              ren,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata,
  input  logic              wen,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (ren) begin
      rdata <= mem[raddr];
    end
    if (wen) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (wstrb[b]) begin
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axil_sram_responder.sv
// AXI4-Lite slave in front of a word array, with per-direction response latency.
// One transaction at a time; a read wins over a write requested in the same cycle.
module axil_sram_responder
  import npc_axi_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(32'h8000_0000),
  parameter int unsigned       READ_LAT  = 1,
  parameter int unsigned       WRITE_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  localparam int unsigned LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int unsigned CNT_W   = (LAT_MAX > 0) ? $clog2(LAT_MAX + 1) : 1;
  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(DEPTH * 4);

  axil_sram_state_t  state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              aw_lat, aw_lat_d;
  logic              w_lat, w_lat_d;
  logic              rvalid_d, bvalid_d;
  logic              rd_done, wr_commit;

  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;

  logic              ar_hs, aw_hs, w_hs;
  logic [ADDR_W-1:0] rd_off, wr_off;
  logic              rd_hit, wr_hit;
  logic              mem_ren, mem_wen;
  logic [DATA_W-1:0] mem_rdata;

  assign arready = (state == IDLE);
  assign awready = ((state == IDLE) && !arvalid) || ((state == W_COLLECT) && !aw_lat);
  assign wready  = ((state == IDLE) && !arvalid) || ((state == W_COLLECT) && !w_lat);

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // In IDLE the array is addressed straight from araddr so READ_LAT=0 still has data ready.
  assign rd_off = ((state == IDLE) ? araddr : raddr_q) - BASE;
  assign wr_off = waddr_q - BASE;
  assign rd_hit = (rd_off < SPAN);
  assign wr_hit = (wr_off < SPAN);

  assign mem_ren = ar_hs || (state == R_DELAY);
  assign mem_wen = wr_commit && wr_hit && !rst;

  sram_word_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .ren   (mem_ren),
    .raddr (rd_off[IDX_W+1:2]),
    .rdata (mem_rdata),
    .wen   (mem_wen),
    .waddr (wr_off[IDX_W+1:2]),
    .wdata (wdata_q),
    .wstrb (wstrb_q)
  );

  // Next-state and response-control decode.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    aw_lat_d  = aw_lat;
    w_lat_d   = w_lat;
    rvalid_d  = rvalid;
    bvalid_d  = bvalid;
    rd_done   = 1'b0;
    wr_commit = 1'b0;

    case (state)
      IDLE: begin
        if (arvalid) begin
          state_d = R_DELAY;
          cnt_d   = CNT_W'(READ_LAT);
        end else begin
          aw_lat_d = awvalid;
          w_lat_d  = wvalid;
          if (awvalid && wvalid) begin
            state_d = W_DELAY;
            cnt_d   = CNT_W'(WRITE_LAT);
          end else if (awvalid || wvalid) begin
            state_d = W_COLLECT;
          end
        end
      end
      W_COLLECT: begin
        if (aw_hs) aw_lat_d = 1'b1;
        if (w_hs)  w_lat_d  = 1'b1;
        if ((aw_lat || aw_hs) && (w_lat || w_hs)) begin
          state_d = W_DELAY;
          cnt_d   = CNT_W'(WRITE_LAT);
        end
      end
      R_DELAY: begin
        if (cnt == '0) begin
          rd_done  = 1'b1;
          rvalid_d = 1'b1;
          state_d  = R_RESP;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      R_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      W_DELAY: begin
        if (cnt == '0) begin
          wr_commit = 1'b1;
          bvalid_d  = 1'b1;
          state_d   = W_RESP;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d = 1'b0;
          aw_lat_d = 1'b0;
          w_lat_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      aw_lat <= 1'b0;
      w_lat  <= 1'b0;
      rvalid <= 1'b0;
      bvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
      bresp  <= RESP_OKAY;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      aw_lat <= aw_lat_d;
      w_lat  <= w_lat_d;
      rvalid <= rvalid_d;
      bvalid <= bvalid_d;
      if (rd_done) begin
        rdata <= rd_hit ? mem_rdata : '0;
        rresp <= rd_hit ? RESP_OKAY : RESP_DECERR;
      end
      if (wr_commit) begin
        bresp <= wr_hit ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  // Request capture; qualified by handshakes so no reset is needed.
  always_ff @(posedge clk) begin
    if (ar_hs) raddr_q <= araddr;
    if (aw_hs) waddr_q <= awaddr;
    if (w_hs) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

endmodule

// File: tb/tb_axil_sram_responder.sv
// Randomised self-checking bench for axil_sram_responder against a transaction-level
// memory model with handshake-relative latency expectations.
module tb_axil_sram_responder;
  import npc_axi_pkg::*;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DEPTH     = 4096;
  localparam int unsigned READ_LAT  = 1;
  localparam int unsigned WRITE_LAT = 1;
  localparam logic [31:0] BASE      = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  always #5 clk = ~clk;

  axil_sram_responder #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .BASE      (BASE),
    .READ_LAT  (READ_LAT),
    .WRITE_LAT (WRITE_LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory model and open-transaction bookkeeping
  logic [31:0] m_mem [int unsigned];
  bit          m_rd_open = 0, m_wr_open = 0, m_aw_got = 0, m_w_got = 0;
  int unsigned m_r_due = 0, m_b_due = 0;
  logic [31:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0, m_bresp = '0;
  bit          chk_en = 0;

  function automatic bit in_rng(input logic [31:0] a);
    return (a - BASE) < 32'(DEPTH * 4);
  endfunction

  function automatic int unsigned key_of(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  // Cycle-by-cycle comparison of every output against the model
  logic busy;
  always @(negedge clk) begin
    if (chk_en) begin
      busy = m_rd_open || m_wr_open;
      chk("arready", 32'(arready), 32'(!busy));
      chk("awready", 32'(awready), 32'((!busy && !arvalid) || (m_wr_open && !m_aw_got)));
      chk("wready", 32'(wready), 32'((!busy && !arvalid) || (m_wr_open && !m_w_got)));
      chk("rvalid", 32'(rvalid), 32'(m_rd_open && (cyc >= m_r_due)));
      if (rvalid) begin
        chk("rdata", rdata, m_rdata);
        chk("rresp", 32'(rresp), 32'(m_rresp));
      end
      chk("bvalid", 32'(bvalid), 32'(m_wr_open && m_aw_got && m_w_got && (cyc >= m_b_due)));
      if (bvalid) chk("bresp", 32'(bresp), 32'(m_bresp));
    end
  end

  // Transaction request set up by the helper tasks
  bit          e_rd, e_wr;
  logic [31:0] e_araddr, e_awaddr, e_wdata;
  logic [3:0]  e_wstrb;
  int          e_aw_start, e_w_start, e_r_stall;
  logic [31:0] last_rdata;
  logic [1:0]  last_rresp, last_bresp;
  int          r_lat, b_lat;

  task automatic run_txn();
    bit ar_got = 0, r_done = 0, b_done = 0, r_seen = 0, b_seen = 0;
    bit ar_hs, aw_hs, w_hs, r_hs, b_hs;
    int unsigned ar_cyc = 0, wr_cyc = 0;
    int stall = e_r_stall;
    m_aw_got = 0;
    m_w_got  = 0;
    for (int k = 0; k < 200; k++) begin
      arvalid = e_rd && !ar_got;
      araddr  = arvalid ? e_araddr : $urandom;
      awvalid = e_wr && !m_aw_got && (k >= e_aw_start);
      awaddr  = e_awaddr;
      wvalid  = e_wr && !m_w_got && (k >= e_w_start);
      wdata   = e_wdata;
      wstrb   = e_wstrb;
      rready  = (stall == 0) && ((e_r_stall > 0) || ($urandom_range(0, 3) != 0));
      bready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      ar_hs = arvalid && arready;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      r_hs  = rvalid && rready;
      b_hs  = bvalid && bready;
      if (rvalid && !r_seen) begin r_seen = 1; r_lat = int'(cyc - ar_cyc); end
      if (rvalid && stall > 0) stall--;
      if (bvalid && !b_seen) begin b_seen = 1; b_lat = int'(cyc - wr_cyc); end
      if (r_hs) begin last_rdata = rdata; last_rresp = rresp; end
      if (b_hs) last_bresp = bresp;
      @(posedge clk);
      #1;
      if (ar_hs) begin
        ar_got    = 1;
        ar_cyc    = cyc;
        m_rd_open = 1;
        m_r_due   = cyc + 1 + READ_LAT;
        m_rdata   = in_rng(e_araddr) ? m_mem[key_of(e_araddr)] : 32'h0;
        m_rresp   = in_rng(e_araddr) ? RESP_OKAY : RESP_DECERR;
      end
      if (aw_hs) begin m_aw_got = 1; m_wr_open = 1; end
      if (w_hs)  begin m_w_got  = 1; m_wr_open = 1; end
      if ((aw_hs || w_hs) && m_aw_got && m_w_got) begin
        wr_cyc  = cyc;
        m_b_due = cyc + 1 + WRITE_LAT;
        m_bresp = in_rng(e_awaddr) ? RESP_OKAY : RESP_DECERR;
      end
      if (r_hs) begin m_rd_open = 0; r_done = 1; end
      if (b_hs) begin
        if (in_rng(e_awaddr)) begin
          for (int b = 0; b < 4; b++)
            if (e_wstrb[b]) m_mem[key_of(e_awaddr)][8*b +: 8] = e_wdata[8*b +: 8];
        end
        m_wr_open = 0;
        b_done    = 1;
      end
      if ((!e_rd || r_done) && (!e_wr || b_done)) begin
        arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0;
        return;
      end
    end
    chk("txn_timeout", 32'd0, 32'd1);
    arvalid = 0; awvalid = 0; wvalid = 0; rready = 0; bready = 0;
  endtask

  task automatic rd(input logic [31:0] a, input int stall);
    e_rd = 1; e_wr = 0; e_araddr = a; e_r_stall = stall;
    run_txn();
  endtask

  // lead > 0: W presented lead cycles before AW; lead < 0: AW first
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    e_rd = 0; e_wr = 1; e_awaddr = a; e_wdata = d; e_wstrb = s; e_r_stall = 0;
    e_w_start  = (lead < 0) ? -lead : 0;
    e_aw_start = (lead > 0) ? lead : 0;
    run_txn();
  endtask

  task automatic both(input logic [31:0] ra, input logic [31:0] wa, input logic [31:0] d, input logic [3:0] s);
    e_rd = 1; e_wr = 1; e_araddr = ra; e_awaddr = wa; e_wdata = d; e_wstrb = s;
    e_r_stall = 0; e_aw_start = 0; e_w_start = 0;
    run_txn();
  endtask

  logic [31:0] ra, wa;

  initial begin
    rst = 1; araddr = '0; arvalid = 0; rready = 0; awaddr = '0; awvalid = 0;
    wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_arready", 32'(arready), 32'd1);
    chk("reset_awready", 32'(awready), 32'd1);
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_bvalid", 32'(bvalid), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_rresp", 32'(rresp), 32'd0);
    chk("reset_bresp", 32'(bresp), 32'd0);
    @(posedge clk);
    #1 chk_en = 1;

    for (int i = 0; i < 8; i++) wr(BASE + 32'(4 * i), 32'hA5A5_0000 | 32'(i), 4'hF, 0);

    wr(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0);
    chk("wr_bvalid_latency", 32'(b_lat), 32'd2);
    chk("wr_bresp_okay", 32'(last_bresp), 32'd0);
    rd(32'h8000_0010, 0);
    chk("rd_full_word", last_rdata, 32'hDEAD_BEEF);
    chk("rd_rvalid_latency", 32'(r_lat), 32'd2);
    chk("rd_rresp_okay", 32'(last_rresp), 32'd0);

    wr(32'h8000_0010, 32'h0000_AA00, 4'b0010, 0);
    rd(32'h8000_0010, 0);
    chk("rd_byte_strobe", last_rdata, 32'hDEAD_AAEF);

    wr(32'h8000_0014, 32'h1234_5678, 4'hF, 3);
    chk("w_first_bvalid_latency", 32'(b_lat), 32'd2);
    rd(32'h8000_0014, 0);
    chk("w_first_data", last_rdata, 32'h1234_5678);

    both(32'h8000_0010, 32'h8000_0018, 32'hCAFE_F00D, 4'hF);
    chk("both_read_old", last_rdata, 32'hDEAD_AAEF);
    rd(32'h8000_0018, 0);
    chk("both_write_after", last_rdata, 32'hCAFE_F00D);

    rd(32'h8000_0010, 5);
    chk("stall_read", last_rdata, 32'hDEAD_AAEF);

    rd(32'h7FFF_FFFC, 0);
    chk("below_base_rresp", 32'(last_rresp), 32'd3);
    chk("below_base_rdata", last_rdata, 32'd0);
    rd(32'h8000_4000, 0);
    chk("past_end_rresp", 32'(last_rresp), 32'd3);
    wr(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 0);
    chk("past_end_bresp", 32'(last_bresp), 32'd3);
    rd(BASE, 0);
    chk("past_end_no_alias", last_rdata, 32'hA5A5_0000);

    // Reset lands on the commit edge of a pending write
    chk_en = 0;
    awaddr = BASE + 32'd8; wdata = 32'h1234_5678; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    chk("rst_wr_accept", 32'(awready && wready), 32'd1);
    @(posedge clk);
    #1 awvalid = 0; wvalid = 0;
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    m_rd_open = 0; m_wr_open = 0; m_aw_got = 0; m_w_got = 0;
    @(posedge clk);
    #1 chk_en = 1;
    rd(BASE + 32'd8, 0);
    chk("rst_no_commit", last_rdata, 32'hA5A5_0002);

    for (int n = 0; n < 200; n++) begin
      ra = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      wa = BASE + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) == 1) ? BASE - 32'(4 * $urandom_range(1, 8)) : BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 64));
      if ($urandom_range(0, 7) == 0) wa = BASE + 32'(DEPTH * 4) + 32'(4 * $urandom_range(0, 16));
      case ($urandom_range(0, 2))
        0: rd(ra, int'($urandom_range(0, 3)));
        1: wr(wa, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3);
        default: both(ra, wa, $urandom, 4'($urandom));
      endcase
    end

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
